// File: rtl/mips_cpu_hilo_unit_if.sv
// Issue/result bundle between the EX stage and the HI/LO unit.
interface mips_cpu_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       alucontrol;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;

  modport master (
    output start, alucontrol, srca, srcb,
    input  busy, stall, done, hi, lo, result
  );

  modport slave (
    input  start, alucontrol, srca, srcb,
    output busy, stall, done, hi, lo, result
  );
endinterface

// File: rtl/mips_cpu_hilo_unit.sv
// HI/LO unit: owns HI/LO, iterative MULT/MULTU/DIV/DIVU, MTHI/MTLO/MFHI/MFLO.
// Define HILO_FAST_MULT_EN for a single-cycle multiplier (divide stays iterative).
module mips_cpu_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input logic                 clk,
  input logic                 reset_n,
  mips_cpu_hilo_unit_if.slave bus
);

  localparam int CW = $clog2(ITER);

  localparam logic [4:0] OP_MULTU = 5'b00111;
  localparam logic [4:0] OP_MULT  = 5'b01000;
  localparam logic [4:0] OP_DIV   = 5'b01111;
  localparam logic [4:0] OP_DIVU  = 5'b10000;
  localparam logic [4:0] OP_MTHI  = 5'b10001;
  localparam logic [4:0] OP_MTLO  = 5'b10010;
  localparam logic [4:0] OP_MFHI  = 5'b11010;
  localparam logic [4:0] OP_MFLO  = 5'b11011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic               done_q, done_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     div_top;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  function automatic logic is_hilo(input logic [4:0] code);
    case (code)
      OP_MULTU, OP_MULT, OP_DIV, OP_DIVU,
      OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  assign signed_op = (bus.alucontrol == OP_MULT) || (bus.alucontrol == OP_DIV);
  assign a_neg     = signed_op & bus.srca[WIDTH-1];
  assign b_neg     = signed_op & bus.srcb[WIDTH-1];
  assign a_mag     = a_neg ? -bus.srca : bus.srca;
  assign b_mag     = b_neg ? -bus.srcb : bus.srcb;

  // acc_q holds {remainder, quotient} for divide and {partial, multiplier} for multiply
  assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = {1'b0, div_top} - {2'b00, opb_q};
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);

  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign prod_fix = neg_res_q ? -acc_q : acc_q;

`ifdef HILO_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.alucontrol)
            OP_MULT, OP_MULTU: begin
              opb_d     = a_mag;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              is_div_d  = 1'b0;
              div0_d    = 1'b0;
              cnt_d     = '0;
`ifdef HILO_FAST_MULT_EN
              acc_d     = fast_prod;
              state_d   = FIX;
`else
              acc_d     = {{WIDTH{1'b0}}, b_mag};
              state_d   = RUN;
`endif
            end
            OP_DIV, OP_DIVU: begin
              acc_d     = {{WIDTH{1'b0}}, a_mag};
              opb_d     = b_mag;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              is_div_d  = 1'b1;
              div0_d    = (bus.srcb == '0);
              cnt_d     = '0;
              state_d   = RUN;
            end
            OP_MTHI: hi_d = bus.srca;
            OP_MTLO: lo_d = bus.srca;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (is_div_q) begin
          acc_d = div_diff[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          // A zero divisor leaves the dividend magnitude as remainder; re-signing it yields srca
          lo_d = div0_q ? '1 : quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state_q != IDLE);
    bus.done  = done_q;
    bus.hi    = hi_q;
    bus.lo    = lo_q;
    bus.stall = bus.start & (state_q != IDLE) & is_hilo(bus.alucontrol);
    case (bus.alucontrol)
      OP_MFHI: bus.result = hi_q;
      OP_MFLO: bus.result = lo_q;
      default: bus.result = '0;
    endcase
  end

endmodule
